// File: rtl/fsm_seq_ctrl_pkg.sv
// Shared types for the Moore-block sequencer: FSM state encoding, default widths
// and the buffered stimulus vector.
package fsm_ctrl_pkg;

   localparam int unsigned DEF_SW_W  = 2;
   localparam int unsigned DEF_CNT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_DRIVE,
      S_STEP,
      S_CHECK,
      S_DONE
   } seq_state_t;

   typedef struct packed {
      logic [DEF_SW_W-1:0] sw;
      logic                exp;
   } vec_t;

endpackage

// File: rtl/fsm_seq_ctrl_vec_fifo.sv
// Synchronous FIFO of stimulus vectors with push, pop and flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module vec_fifo
   import fsm_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter type         T     = vec_t
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  T                         wr_data,
   output T                         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   T           mem [DEPTH];
   logic [AW:0] wr_q, wr_d;
   logic [AW:0] rd_q, rd_d;
   logic        do_push;
   logic        do_pop;

   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty = (wr_q == rd_q);
   assign count = wr_q - rd_q;
   assign head  = mem[rd_q[AW-1:0]];

   always_comb begin
      do_push = push && !full && !flush;
      do_pop  = pop && !empty && !flush;
      wr_d    = wr_q;
      rd_d    = rd_q;
      if (flush) begin
         rd_d = wr_q;
      end else begin
         if (do_push) wr_d = wr_q + (AW+1)'(1);
         if (do_pop)  rd_d = rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/fsm_seq_ctrl.sv
// Sequencer for the 2-state Moore block: buffers (switch, expected) vectors, resets
// the block, steps it once per vector and counts output mismatches.
module fsm_seq_ctrl
   import fsm_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned SW_W  = DEF_SW_W,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             vec_valid,
   input  logic [SW_W-1:0]  vec_sw,
   input  logic             vec_exp,
   output logic             vec_ready,
   input  logic             start,
   input  logic             abort,
   output logic [SW_W-1:0]  dut_sw,
   output logic             dut_step,
   output logic             dut_rst,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] step_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef struct packed {
      logic [SW_W-1:0] sw;
      logic            exp;
   } vec_w_t;

   seq_state_t       state_q, state_d;
   vec_w_t           wr_vec, head;
   logic             fifo_full, fifo_empty;
   logic [AW:0]      fifo_cnt;
   logic             push, pop, flush;
   logic             clr, step_inc, err_inc;
   logic [SW_W-1:0]  sw_q, sw_d;
   logic             exp_q, exp_d;
   logic             step_q, step_d;
   logic             rst_q, rst_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [CNT_W-1:0] stepc_q, stepc_d;

   assign busy      = (state_q != S_IDLE);
   assign vec_ready = !busy && !fifo_full;
   assign push      = vec_valid && vec_ready;
   assign wr_vec    = '{sw: vec_sw, exp: vec_exp};

   vec_fifo #(
      .DEPTH (DEPTH),
      .T     (vec_w_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .wr_data (wr_vec),
      .head    (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_cnt)
   );

   // The head is popped on leaving STEP with its expected bit parked in exp_q, so
   // in CHECK the FIFO head is already the next vector and can load dut_sw directly.
   always_comb begin
      state_d  = state_q;
      sw_d     = sw_q;
      exp_d    = exp_q;
      pop      = 1'b0;
      flush    = 1'b0;
      clr      = 1'b0;
      step_inc = 1'b0;
      err_inc  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               clr     = 1'b1;
               state_d = fifo_empty ? S_DONE : S_RST;
            end
         end
         S_RST: begin
            state_d = S_DRIVE;
            sw_d    = head.sw;
         end
         S_DRIVE: begin
            state_d  = S_STEP;
            step_inc = 1'b1;
         end
         S_STEP: begin
            state_d = S_CHECK;
            pop     = 1'b1;
            exp_d   = head.exp;
         end
         S_CHECK: begin
            err_inc = (dut_out != exp_q);
            if (fifo_empty) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DRIVE;
               sw_d    = head.sw;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d  = S_IDLE;
         flush    = 1'b1;
         clr      = 1'b0;
         pop      = 1'b0;
         step_inc = 1'b0;
         err_inc  = 1'b0;
         sw_d     = sw_q;
         exp_d    = exp_q;
      end
   end

   always_comb begin
      rst_d   = (state_d == S_RST);
      step_d  = (state_d == S_STEP);
      done_d  = (state_d == S_DONE);
      stepc_d = stepc_q;
      err_d   = err_q;
      if (clr) begin
         stepc_d = '0;
         err_d   = '0;
      end else begin
         if (step_inc && (stepc_q != '1)) stepc_d = stepc_q + CNT_W'(1);
         if (err_inc && (err_q != '1))    err_d   = err_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         sw_q    <= '0;
         exp_q   <= 1'b0;
         step_q  <= 1'b0;
         rst_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= '0;
         stepc_q <= '0;
      end else begin
         state_q <= state_d;
         sw_q    <= sw_d;
         exp_q   <= exp_d;
         step_q  <= step_d;
         rst_q   <= rst_d;
         done_q  <= done_d;
         err_q   <= err_d;
         stepc_q <= stepc_d;
      end
   end

   assign dut_sw   = sw_q;
   assign dut_step = step_q;
   assign dut_rst  = rst_q;
   assign done     = done_q;
   assign err_cnt  = err_q;
   assign step_cnt = stepc_q;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed bench for fsm_seq_ctrl with a stand-in Moore block whose output after a
// step is the XNOR of the two switch bits.
module tb_fsm_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       vec_valid;
   logic [1:0] vec_sw;
   logic       vec_exp;
   logic       vec_ready;
   logic       start;
   logic       abort;
   logic [1:0] dut_sw;
   logic       dut_step;
   logic       dut_rst;
   logic       dut_out;
   logic       busy;
   logic       done;
   logic [7:0] err_cnt;
   logic [7:0] step_cnt;

   int checks   = 0;
   int failures = 0;

   logic [1:0] vsw [16];
   int         nv = 0;
   logic       moore_q = 1'b0;

   fsm_seq_ctrl #(.DEPTH(8), .SW_W(2), .CNT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .vec_valid (vec_valid),
      .vec_sw    (vec_sw),
      .vec_exp   (vec_exp),
      .vec_ready (vec_ready),
      .start     (start),
      .abort     (abort),
      .dut_sw    (dut_sw),
      .dut_step  (dut_step),
      .dut_rst   (dut_rst),
      .dut_out   (dut_out),
      .busy      (busy),
      .done      (done),
      .err_cnt   (err_cnt),
      .step_cnt  (step_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dut_rst)       moore_q <= 1'b0;
      else if (dut_step) moore_q <= ~^dut_sw;
   end
   assign dut_out = moore_q;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [1:0] sw, input logic e);
      vec_valid = 1'b1;
      vec_sw    = sw;
      vec_exp   = e;
      tick();
      vec_valid = 1'b0;
      vsw[nv]   = sw;
      nv++;
   endtask

   // Runs the buffered nv vectors, checking every output cycle by cycle.
   task automatic run(input int n, input int exp_err);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 3*n + 3; c++) begin
         chk("rst",  dut_rst,  c == 1);
         chk("step", dut_step, (c >= 3) && (c <= 3*n) && (c % 3 == 0));
         chk("done", done,     c == 3*n + 2);
         chk("busy", busy,     c <= 3*n + 2);
         if ((c >= 3) && (c <= 3*n) && (c % 3 == 0)) chk("sw", dut_sw, vsw[(c-3)/3]);
         tick();
      end
      chk("step_cnt", step_cnt, n);
      chk("err_cnt",  err_cnt,  exp_err);
      nv = 0;
   endtask

   initial begin
      reset     = 1'b0;
      vec_valid = 1'b0;
      vec_sw    = 2'd0;
      vec_exp   = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      #12;
      chk("rst_busy",  busy,      0);
      chk("rst_ready", vec_ready, 1);
      chk("rst_out",   {dut_sw, dut_step, dut_rst, done}, 0);
      chk("rst_cnt",   {err_cnt, step_cnt}, 0);
      tick();
      reset = 1'b1;
      tick();

      // Matching expectations
      push(2'd0, 1'b1); push(2'd1, 1'b0); push(2'd2, 1'b0); push(2'd3, 1'b1);
      run(4, 0);

      // Inverted expectations
      push(2'd0, 1'b0); push(2'd1, 1'b1); push(2'd2, 1'b1); push(2'd3, 1'b0);
      run(4, 4);

      // Fill to DEPTH; the 9th push must be dropped
      for (int i = 0; i < 8; i++) begin
         chk("fill_ready", vec_ready, 1);
         push(2'(i % 4), ((i % 4) == 0) || ((i % 4) == 3));
      end
      chk("full_ready", vec_ready, 0);
      vec_valid = 1'b1;
      vec_sw    = 2'd1;
      vec_exp   = 1'b1;
      tick();
      vec_valid = 1'b0;
      chk("full_ready2", vec_ready, 0);
      run(8, 0);

      // Abort in the second vector's STEP
      push(2'd1, 1'b0); push(2'd2, 1'b0); push(2'd3, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("ab_step_pre", dut_step, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_busy",  busy,      0);
      chk("ab_step",  dut_step,  0);
      chk("ab_done",  done,      0);
      chk("ab_ready", vec_ready, 1);
      chk("ab_scnt",  step_cnt,  2);
      chk("ab_ecnt",  err_cnt,   0);
      tick();
      chk("ab_done2", done, 0);
      nv = 0;

      // Start with the (flushed) empty buffer
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("em_done", done,     1);
      chk("em_busy", busy,     1);
      chk("em_rst",  dut_rst,  0);
      chk("em_step", dut_step, 0);
      chk("em_scnt", step_cnt, 0);
      tick();
      chk("em_done2", done, 0);
      chk("em_busy2", busy, 0);

      // Asynchronous reset during the third vector's DRIVE
      push(2'd1, 1'b0); push(2'd2, 1'b0); push(2'd3, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("ar_sw_pre", dut_sw,   3);
      chk("ar_scnt",   step_cnt, 2);
      reset = 1'b0;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_out",  {dut_sw, dut_step, dut_rst, done}, 0);
      chk("ar_cnt",  {err_cnt, step_cnt}, 0);
      tick();
      reset = 1'b1;
      tick();
      chk("ar_ready", vec_ready, 1);
      nv = 0;
      push(2'd3, 1'b1); push(2'd1, 1'b0);
      run(2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fsm_seq_ctrl.md
# fsm_seq_ctrl

Sequencer for the 2-state Moore block. It buffers (switch, expected-output) vector pairs, resets the Moore block, applies each switch value and issues one single-cycle step enable per vector, then samples the block's registered output and counts mismatches. It sits between the bench/host stimulus side and the Moore block's `sw_in`/`ctrl_in`/`reset`/`out` pins.

## Interface
- `DEPTH`, 8: vector buffer depth; must be a power of 2, ≥2.
- `SW_W`, 2: switch vector width.
- `CNT_W`, 8: width of `err_cnt` and `step_cnt`.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `vec_valid`  in  1  push request for one vector.
- `vec_sw`  in  SW_W  switch value to apply.
- `vec_exp`  in  1  expected Moore output after the step.
- `vec_ready`  out  1  push accepted when `vec_valid && vec_ready`.
- `start`  in  1  pulse; begins a run (honoured only in IDLE).
- `abort`  in  1  synchronous; ends a run and flushes the buffer.
- `dut_sw`  out  SW_W  to Moore `sw_in`.
- `dut_step`  out  1  to Moore `ctrl_in`.
- `dut_rst`  out  1  to Moore `reset` (active-high, synchronous at the Moore block).
- `dut_out`  in  1  from Moore `out`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `err_cnt`  out  CNT_W  mismatches in the current or last run.
- `step_cnt`  out  CNT_W  steps issued in the current or last run.

## Operation
- States: IDLE, RST, DRIVE, STEP, CHECK, DONE.
- IDLE:
  - `vec_ready = !full`.
  - On `start` with a non-empty buffer: clear `err_cnt`/`step_cnt`, go to RST.
  - On `start` with an empty buffer: clear the counters, go to DONE.
- RST: `dut_rst=1` for one cycle, then DRIVE.
- DRIVE: `dut_sw` = head `vec_sw`, `dut_step=0`; one settle cycle, then STEP.
- STEP: `dut_sw` held, `dut_step=1` for exactly one cycle; `step_cnt++`; then CHECK.
- CHECK:
  - Sample `dut_out` and compare it with head `vec_exp`; on mismatch `err_cnt++`.
  - Pop the head.
  - Go to DRIVE if entries remain after the pop, otherwise DONE.
- DONE: `done=1` for one cycle, then IDLE.
- Counters saturate at 2^CNT_W−1. They are cleared only by `start` and `reset`.
- `vec_ready=0` while `busy`. Pushes during a run are not accepted.
- `abort` (any non-IDLE state):
  - Next state is IDLE and the buffer is flushed.
  - `dut_step`/`dut_rst` are forced low in the abort cycle.
  - No `done` pulse. Counters keep their values.
  - `abort` in IDLE flushes the buffer only.
- `abort` and `start` in the same cycle: `abort` wins.
- `dut_sw` holds its last driven value outside DRIVE/STEP; reset value 0.

## Timing
- All outputs are registered except `vec_ready` and `busy` (decoded from state and full flag).
- Reset values: state IDLE, buffer empty, `dut_sw=0`, `dut_step=0`, `dut_rst=0`, `done=0`, `err_cnt=0`, `step_cnt=0`.
- Run latency for N≥1 vectors:
  - `start` sampled at edge 0; RST at cycle 1.
  - Vector k occupies cycles 2+3k (DRIVE), 3+3k (STEP) and 4+3k (CHECK).
  - `done` high in cycle 2+3N.
  - `busy` is high from cycle 1 through cycle 2+3N.
- Empty-buffer `start`: `done` high in cycle 1; no `dut_rst`, no step.
- CHECK samples `dut_out` one cycle after the `dut_step` edge, when the Moore block's registered output reflects the step.
- Buffer full: `vec_ready=0`. A push at count DEPTH−1 makes it full on the next cycle.
- `reset` asserted mid-run: all state and outputs return to reset values immediately. The Moore block is re-reset by the next run's RST.

## Structure
- Package `fsm_ctrl_pkg`: state enum `seq_state_t`, default `SW_W`/`CNT_W` constants, and the vector struct `{sw, exp}`.
- Sub-module `vec_fifo`:
  - Synchronous FIFO of the `{sw, exp}` struct with push, pop and flush.
  - Full/empty via (log2 DEPTH)+1-bit pointers, so wrap-around is unambiguous.
  - Asynchronous active-low reset.
- Top: FSM, counters, output registers.

## Test plan
- Push (0,1), (1,0), (2,0), (3,1), then `start` → four `dut_step` pulses at cycles 3, 6, 9, 12; `done` at cycle 14; `err_cnt=0`, `step_cnt=4`.
- Same stimulus with every `vec_exp` inverted → `err_cnt=4`, `step_cnt=4`, same timing.
- Push DEPTH=8 vectors → `vec_ready=0` after the 8th; a 9th `vec_valid` is dropped; run gives `step_cnt=8`.
- `start` with an empty buffer → `done` at cycle 1, `busy` for one cycle, counters 0, no `dut_rst`/`dut_step`.
- `abort` during the 2nd vector's STEP → IDLE next cycle, `step_cnt=2`, no `done`, buffer empty (`vec_ready=1`).
- `reset` low during the 3rd vector's DRIVE → all outputs 0 and state IDLE asynchronously; a following run of 2 vectors completes with `step_cnt=2`.
